// File: rtl/rv32_load_store_unit_pkg.sv
// Shared types for the RV32 load/store path: memory ops, request bundle, causes, LSU states.
// Latency: none (types and pure helper functions only).
// Backpressure: not applicable.
package rv32_types;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LBU = 4'd2,
    MEM_LH  = 4'd3,
    MEM_LHU = 4'd4,
    MEM_LW  = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_t;

  typedef struct packed {
    mem_op_t     op;
    logic [31:0] addr;
    logic [31:0] data;
  } memory_request_t;

  typedef enum logic [1:0] {
    CAUSE_NONE           = 2'b00,
    CAUSE_LOAD_MISALIGN  = 2'b01,
    CAUSE_STORE_MISALIGN = 2'b10,
    CAUSE_ACCESS_FAULT   = 2'b11
  } lsu_cause_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_DATA = 2'd1,
    RESP      = 2'd2
  } lsu_state_t;

  function automatic logic is_load(input mem_op_t op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
           (op == MEM_LHU) || (op == MEM_LW);
  endfunction

endpackage

// File: rtl/rv32_load_extract.sv
// Selects the addressed byte/half/word from a memory word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module rv32_load_extract
  import rv32_types::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select from the byte offset, then extend according to the load flavour.
  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = word[{off[1], 4'b0000} +: 16];
    case (op)
      MEM_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: result = {24'd0, byte_sel};
      MEM_LH:  result = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: result = {16'd0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/rv32_load_store_unit.sv
// Load/store unit: checks alignment/range, issues to memory port B, returns one tagged response.
// Latency: store or exception 1 cycle accept-to-resp_valid; load 2 cycles.
// Backpressure: resp_valid holds until resp_ready; req_ready drops while a response is stalled.
module rv32_load_store_unit
  import rv32_types::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  mem_op_t          req_op,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_exc,
  output logic [1:0]       resp_cause,
  output memory_request_t  mem_req,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata
);

  lsu_state_t       state_q, state_d;
  mem_op_t          op_q, op_d;
  logic [1:0]       off_q, off_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      data_q, data_d;
  logic             exc_q, exc_d;
  lsu_cause_t       cause_q, cause_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;

  logic             accept;
  logic             misaligned;
  logic             fault;
  logic             exc;
  lsu_cause_t       cause;
  mem_op_t          issue_op;
  logic [31:0]      issue_addr;
  logic [31:0]      issue_data;
  logic [31:0]      extracted;

  rv32_load_extract u_extract (
    .op     (op_q),
    .off    (off_q),
    .word   (mem_rdata),
    .result (extracted)
  );

  // Handshake, alignment/range check and the memory request for the accept cycle.
  always_comb begin
    req_ready  = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
    // Reset blocks acceptance so nothing (in particular no store) is issued.
    accept     = req_valid && req_ready && !reset;
    misaligned = 1'b0;
    if (((req_op == MEM_LH) || (req_op == MEM_LHU) || (req_op == MEM_SH)) && req_addr[0])
      misaligned = 1'b1;
    if (((req_op == MEM_LW) || (req_op == MEM_SW)) && (req_addr[1:0] != 2'b00))
      misaligned = 1'b1;
    // mem_ready reflects the address we drive below, which is req_addr when accepting.
    fault = !misaligned && !mem_ready;
    exc   = misaligned || fault;
    cause = CAUSE_NONE;
    if (misaligned)
      cause = is_load(req_op) ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN;
    else if (fault)
      cause = CAUSE_ACCESS_FAULT;
    issue_op   = MEM_NOP;
    issue_addr = addr_q;
    issue_data = wdata_q;
    if (accept) begin
      issue_addr = req_addr;
      issue_data = req_wdata;
      // Loads always fetch the whole word; stores pass data unshifted for lane steering.
      if (!exc)
        issue_op = is_load(req_op) ? MEM_LW : req_op;
    end
  end

  assign mem_req = '{op: issue_op, addr: issue_addr, data: issue_data};

  // Next-state and holding-register updates for the IDLE/LOAD_DATA/RESP sequence.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    tag_d   = tag_q;
    data_d  = data_q;
    exc_d   = exc_q;
    cause_d = cause_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      LOAD_DATA: begin
        data_d  = extracted;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready)
          state_d = IDLE;
      end
      default: state_d = state_q;
    endcase
    if (accept) begin
      op_d    = req_op;
      off_d   = req_addr[1:0];
      tag_d   = req_tag;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      exc_d   = exc;
      cause_d = cause;
      data_d  = 32'd0;
      state_d = (is_load(req_op) && !exc) ? LOAD_DATA : RESP;
    end
  end

  // State and holding registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= MEM_NOP;
      off_q   <= 2'd0;
      tag_q   <= '0;
      data_q  <= 32'd0;
      exc_q   <= 1'b0;
      cause_q <= CAUSE_NONE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
      cause_q <= cause_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_data  = data_q;
  assign resp_tag   = tag_q;
  assign resp_exc   = exc_q;
  assign resp_cause = cause_q;

endmodule

// File: tb/tb_rv32_load_store_unit.sv
// Bench for rv32_load_store_unit: memory model on port B plus a byte-level reference model.
// Latency: checks 1-cycle store/exception and 2-cycle load responses.
// Backpressure: exercises stalled responses and same-cycle response/request handshakes.
module tb_rv32_load_store_unit;
  import rv32_types::*;

  localparam int TAG_W     = 5;
  localparam int NUM_WORDS = 64;
  localparam int MEM_BYTES = 4 * NUM_WORDS;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  mem_op_t          req_op;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_exc;
  logic [1:0]       resp_cause;
  memory_request_t  mem_req;
  logic             mem_ready;
  logic [31:0]      mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  rv32_load_store_unit #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .resp_exc   (resp_exc),
    .resp_cause (resp_cause),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory port B: range is only consulted when the LSU drives mem_req.addr = req_addr.
  assign mem_ready = (req_addr < 32'(MEM_BYTES));

  // Out-of-range writes alias into the array so a stray write becomes visible later.
  logic [31:0] mem_words [NUM_WORDS] = '{default: 32'd0};
  always @(posedge clk) begin
    mem_rdata <= mem_words[mem_req.addr[7:2]];
    case (mem_req.op)
      MEM_SB: mem_words[mem_req.addr[7:2]][{mem_req.addr[1:0], 3'b000} +: 8] <= mem_req.data[7:0];
      MEM_SH: mem_words[mem_req.addr[7:2]][{mem_req.addr[1], 4'b0000} +: 16] <= mem_req.data[15:0];
      MEM_SW: mem_words[mem_req.addr[7:2]] <= mem_req.data;
      default: ;
    endcase
  end

  // Reference: byte-addressed little-endian memory and the access rules.
  logic [7:0] ref_bytes [MEM_BYTES] = '{default: 8'd0};

  function automatic void model(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] d, output logic e, output logic [1:0] c);
    int  n;
    bit  st;
    n  = (op == MEM_LH || op == MEM_LHU || op == MEM_SH) ? 2 :
         (op == MEM_LW || op == MEM_SW) ? 4 : 1;
    st = (op == MEM_SB || op == MEM_SH || op == MEM_SW);
    d = 32'd0; e = 1'b0; c = 2'b00;
    if ((addr % n) != 0) begin
      e = 1'b1; c = st ? 2'b10 : 2'b01;
    end else if (addr >= 32'(MEM_BYTES)) begin
      e = 1'b1; c = 2'b11;
    end else if (st) begin
      for (int i = 0; i < n; i++) ref_bytes[addr + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) d[8*i +: 8] = ref_bytes[addr + i];
      if (op == MEM_LB) d = {{24{d[7]}}, d[7:0]};
      if (op == MEM_LH) d = {{16{d[15]}}, d[15:0]};
    end
  endfunction

  // Drives one access with resp_ready high and returns what the DUT produced.
  task automatic access(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [TAG_W-1:0] tag, output logic [31:0] d, output logic e,
                        output logic [1:0] c, output logic [TAG_W-1:0] rtag,
                        output mem_op_t iop, output logic [31:0] iaddr, output int lat);
    int waits;
    waits = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_tag = tag;
    resp_ready = 1'b1;
    #1;
    while (!req_ready && waits < 20) begin
      @(negedge clk); #1; waits++;
    end
    iop   = mem_req.op;
    iaddr = mem_req.addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    d = resp_data; e = resp_exc; c = resp_cause; rtag = resp_tag;
    @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = MEM_NOP; req_addr = 32'd0; req_wdata = 32'd0; req_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (mem_req.op !== MEM_NOP) begin
      n_fail++; $display("FAIL reset_mem_op: got %0d want %0d", mem_req.op, MEM_NOP);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_checks++;
    if (resp_data !== 32'd0) begin n_fail++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    n_checks++;
    if (resp_tag !== '0) begin n_fail++; $display("FAIL reset_resp_tag: got %h want 0", resp_tag); end
    n_checks++;
    if ({resp_exc, resp_cause} !== 3'b000) begin
      n_fail++; $display("FAIL reset_resp_exc_cause: got %b%b want 000", resp_exc, resp_cause);
    end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
  endtask

  typedef struct {
    mem_op_t     op;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          has_known;
    logic [31:0] known;
  } dir_t;

  task automatic test_directed();
    dir_t             tbl [13];
    logic [31:0]      d, ed, ia;
    logic             e, ee;
    logic [1:0]       c, ec;
    logic [TAG_W-1:0] rt, tag;
    mem_op_t          iop, eop;
    int               lat, elat;
    tbl = '{
      '{MEM_SW,  32'h10,       32'hDEADBEEF, 1'b0, 32'h0},
      '{MEM_LW,  32'h10,       32'h0,        1'b1, 32'hDEADBEEF},
      '{MEM_SB,  32'h13,       32'h80,       1'b0, 32'h0},
      '{MEM_LB,  32'h13,       32'h0,        1'b1, 32'hFFFFFF80},
      '{MEM_LBU, 32'h13,       32'h0,        1'b1, 32'h00000080},
      '{MEM_LW,  32'h10,       32'h0,        1'b1, 32'h80ADBEEF},
      '{MEM_LH,  32'h11,       32'h0,        1'b0, 32'h0},
      '{MEM_SW,  32'h12,       32'h1,        1'b0, 32'h0},
      '{MEM_LW,  32'h10,       32'h0,        1'b1, 32'h80ADBEEF},
      '{MEM_LW,  32'h100,      32'h0,        1'b0, 32'h0},
      '{MEM_SW,  32'h100,      32'h12345678, 1'b0, 32'h0},
      '{MEM_LW,  32'hFFFFFFFC, 32'h0,        1'b0, 32'h0},
      '{MEM_LW,  32'h0,        32'h0,        1'b1, 32'h0}
    };
    foreach (tbl[i]) begin
      tag = TAG_W'(i + 3);
      model(tbl[i].op, tbl[i].addr, tbl[i].wd, ed, ee, ec);
      elat = (is_load(tbl[i].op) && !ee) ? 2 : 1;
      eop  = ee ? MEM_NOP : (is_load(tbl[i].op) ? MEM_LW : tbl[i].op);
      access(tbl[i].op, tbl[i].addr, tbl[i].wd, tag, d, e, c, rt, iop, ia, lat);
      n_checks++;
      if (d !== ed) begin n_fail++; $display("FAIL dir%0d_data: got %h want %h", i, d, ed); end
      n_checks++;
      if ({e, c} !== {ee, ec}) begin
        n_fail++; $display("FAIL dir%0d_exc_cause: got %b/%b want %b/%b", i, e, c, ee, ec);
      end
      n_checks++;
      if (rt !== tag) begin n_fail++; $display("FAIL dir%0d_tag: got %h want %h", i, rt, tag); end
      n_checks++;
      if (lat !== elat) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, elat); end
      n_checks++;
      if (iop !== eop) begin n_fail++; $display("FAIL dir%0d_issue_op: got %0d want %0d", i, iop, eop); end
      n_checks++;
      if (ia !== tbl[i].addr) begin n_fail++; $display("FAIL dir%0d_issue_addr: got %h want %h", i, ia, tbl[i].addr); end
      if (tbl[i].has_known) begin
        n_checks++;
        if (d !== tbl[i].known) begin n_fail++; $display("FAIL dir%0d_known: got %h want %h", i, d, tbl[i].known); end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0]      ed, ed2, snap_d;
    logic             ee, ee2;
    logic [1:0]       ec, ec2;
    logic [TAG_W-1:0] snap_t;
    int               waits;
    model(MEM_LHU, 32'h12, 32'h0, ed, ee, ec);
    @(negedge clk);
    req_valid = 1'b1; req_op = MEM_LHU; req_addr = 32'h12; req_tag = 5'd21; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    waits = 0;
    while (!resp_valid && waits < 10) begin @(posedge clk); #1; waits++; end
    n_checks++;
    if (resp_data !== ed || resp_tag !== 5'd21 || resp_exc !== 1'b0) begin
      n_fail++; $display("FAIL stall_first: got %h/%h/%b want %h/15/0", resp_data, resp_tag, resp_exc, ed);
    end
    snap_d = resp_data; snap_t = resp_tag;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_op = MEM_LW; req_addr = 32'h10; req_tag = 5'd9;
      #1;
      n_checks++;
      if (resp_valid !== 1'b1 || resp_data !== snap_d || resp_tag !== snap_t || resp_cause !== 2'b00) begin
        n_fail++; $display("FAIL stall_hold%0d: got %b/%h/%h want 1/%h/%h", k, resp_valid, resp_data, resp_tag, snap_d, snap_t);
      end
      n_checks++;
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_req_ready%0d: got %b want 0", k, req_ready); end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b want 1", req_ready); end
    model(MEM_LW, 32'h10, 32'h0, ed2, ee2, ec2);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_load_gap: got %b want 0", resp_valid); end
    @(posedge clk); #1;
    n_checks++;
    if (resp_valid !== 1'b1 || resp_data !== ed2 || resp_tag !== 5'd9) begin
      n_fail++; $display("FAIL b2b_second: got %b/%h/%h want 1/%h/09", resp_valid, resp_data, resp_tag, ed2);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0]      d, ed, ia;
    logic             e, ee;
    logic [1:0]       c, ec;
    logic [TAG_W-1:0] rt;
    mem_op_t          iop;
    int               lat, stray;
    @(negedge clk);
    req_valid = 1'b1; req_op = MEM_LW; req_addr = 32'h10; req_tag = 5'd7; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_resp_valid: got %b want 0", resp_valid); end
    @(negedge clk);
    req_valid = 1'b1; req_op = MEM_SW; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5; req_tag = 5'd2;
    #1;
    n_checks++;
    if (mem_req.op !== MEM_NOP) begin n_fail++; $display("FAIL rst_store_op: got %0d want %0d", mem_req.op, MEM_NOP); end
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    stray = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_valid) stray++;
    end
    n_checks++;
    if (stray != 0) begin n_fail++; $display("FAIL rst_stray_resp: got %0d responses want 0", stray); end
    model(MEM_LW, 32'h20, 32'h0, ed, ee, ec);
    access(MEM_LW, 32'h20, 32'h0, 5'd4, d, e, c, rt, iop, ia, lat);
    n_checks++;
    if (d !== ed || e !== ee) begin n_fail++; $display("FAIL rst_store_dropped: got %h/%b want %h/%b", d, e, ed, ee); end
  endtask

  task automatic test_random();
    logic [31:0]      addr, wd, d, ed, ia;
    logic             e, ee;
    logic [1:0]       c, ec;
    logic [TAG_W-1:0] rt, tag;
    mem_op_t          op, iop;
    int               lat, elat, sel;
    for (int i = 0; i < 300; i++) begin
      op  = mem_op_t'($urandom_range(1, 8));
      sel = $urandom_range(0, 19);
      addr = (sel == 0) ? 32'hFFFFFFFC : (sel == 1) ? $urandom : 32'($urandom_range(0, MEM_BYTES - 1));
      wd  = $urandom;
      tag = TAG_W'($urandom);
      model(op, addr, wd, ed, ee, ec);
      elat = (is_load(op) && !ee) ? 2 : 1;
      access(op, addr, wd, tag, d, e, c, rt, iop, ia, lat);
      n_checks++;
      if (d !== ed || {e, c} !== {ee, ec} || rt !== tag || lat !== elat) begin
        n_fail++;
        $display("FAIL rnd%0d op%0d addr %h: got %h/%b/%b/%h/%0d want %h/%b/%b/%h/%0d",
                 i, op, addr, d, e, c, rt, lat, ed, ee, ec, tag, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
